// File: rtl/pipe_stage_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_pkg
// Shared definitions for the elastic pipeline stage: default payload width,
// legal depth limits, occupancy-state encoding and a pointer-wrap helper.
// -----------------------------------------------------------------------------
package pipe_stage_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned DEPTH_DEFAULT = 2;
  localparam int unsigned DEPTH_MIN     = 2;
  localparam int unsigned DEPTH_MAX     = 8;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_e;

  // Advance a ring pointer, wrapping explicitly so non-power-of-two depths
  // never step into an unused slot.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pipe_stage_mem.sv
// -----------------------------------------------------------------------------
// pipe_stage_mem
// Entry storage for pipe_stage_elastic: DEPTH entries of payload plus one
// pcincr bit, one synchronous write port and one asynchronous read port.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   wr_en             write strobe
//   wr_addr           write slot
//   wr_data           payload to store
//   wr_pcincr         pcincr bit to store
//   rd_addr           read slot
//   rd_data           payload at rd_addr (combinational)
//   rd_pcincr         pcincr bit at rd_addr (combinational)
// -----------------------------------------------------------------------------
module pipe_stage_mem
  import pipe_stage_pkg::*;
#(
  parameter  int unsigned WIDTH = WIDTH_DEFAULT,
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_pcincr,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_pcincr
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] pcincr_q;

  // NOTE: payload storage has no reset -- stale data is never visible because
  // out_valid gates it, and leaving it unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_addr] <= wr_data;
  end

  // The pcincr column is cleared by reset so no stale bit can ever raise a
  // PC-increment pulse after a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcincr_q <= '0;
    end else if (wr_en) begin
      pcincr_q[wr_addr] <= wr_pcincr;
    end
  end

  assign rd_data   = data_q[rd_addr];
  assign rd_pcincr = pcincr_q[rd_addr];

endmodule

// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
// Elastic FIFO pipeline stage for decoded-instruction bundles. Entries pushed
// become visible one cycle later; in_ready depends on registered occupancy
// only, so there is no combinational path from out_ready to in_ready. Each
// consumed entry whose pcincr bit is set produces one out_pcincr pulse.
// Legal DEPTH range is DEPTH_MIN..DEPTH_MAX from pipe_stage_pkg.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   in_valid/in_ready upstream handshake, in_data/in_pcincr its payload
//   flush             synchronous discard of every entry
//   out_valid/out_ready downstream handshake, out_data head payload
//   out_pcincr        one-cycle pulse when a pcincr entry is consumed
//   count             current occupancy
//   bubble_cnt        (only with PIPE_STAGE_PERF_EN) saturating count of
//                     cycles where downstream was ready but nothing was valid
// -----------------------------------------------------------------------------
module pipe_stage_elastic
  import pipe_stage_pkg::*;
#(
  parameter  int unsigned WIDTH = WIDTH_DEFAULT,
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_pcincr,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_pcincr,
  output logic [CNT_W-1:0] count
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]      bubble_cnt
`endif
);

  logic [CNT_W-1:0] count_q,  count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  occ_e             occ;
  logic             push, pop;
  logic             head_pcincr;

  // Occupancy class decoded from the registered count only.
  always_comb begin
    occ = PARTIAL;
    if (count_q == '0)                    occ = EMPTY;
    else if (count_q == CNT_W'(DEPTH))    occ = FULL;
  end

  assign in_ready  = (occ != FULL);
  assign out_valid = (occ != EMPTY);
  assign count     = count_q;

  assign push = in_valid  & in_ready;
  assign pop  = out_valid & out_ready;

  // NOTE: every output of this block gets its default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      // Any push this cycle is dropped along with the stored entries.
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
      if (pop)  rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  pipe_stage_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (push & ~flush),
    .wr_addr   (wr_ptr_q),
    .wr_data   (in_data),
    .wr_pcincr (in_pcincr),
    .rd_addr   (rd_ptr_q),
    .rd_data   (out_data),
    .rd_pcincr (head_pcincr)
  );

  // One pulse per consumed pcincr entry; a flushed head is not consumed.
  assign out_pcincr = pop & head_pcincr & ~flush;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      bubble_cnt_d = '0;
    end else if (out_ready && !out_valid && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bubble_cnt_q <= '0;
    else      bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
// Drives a DEPTH=2 and a DEPTH=3 instance from the same stimulus and checks
// both every cycle against queue-based models, plus directed literal checks.
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_pcincr = 1'b0;
  logic         out_ready = 1'b0;
  logic         flush = 1'b0;

  logic         in_ready2, out_valid2, out_pcincr2;
  logic [W-1:0] out_data2;
  logic [1:0]   count2;
  logic         in_ready3, out_valid3, out_pcincr3;
  logic [W-1:0] out_data3;
  logic [1:0]   count3;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]  bubble2, bubble3;
  int unsigned  mbub2 = 0, mbub3 = 0;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int pulses3  = 0;

  // Model state: each entry is {pcincr, data}, index 0 is the head.
  logic [W:0] q2[$];
  logic [W:0] q3[$];
  bit         m_push2, m_pop2, m_push3, m_pop3;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.WIDTH(W), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_pcincr(in_pcincr), .in_ready(in_ready2), .flush(flush),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
    .out_pcincr(out_pcincr2), .count(count2)
`ifdef PIPE_STAGE_PERF_EN
    , .bubble_cnt(bubble2)
`endif
  );

  pipe_stage_elastic #(.WIDTH(W), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_pcincr(in_pcincr), .in_ready(in_ready3), .flush(flush),
    .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready),
    .out_pcincr(out_pcincr3), .count(count3)
`ifdef PIPE_STAGE_PERF_EN
    , .bubble_cnt(bubble3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of bounded size, cleared by reset or flush.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q2.delete();
      q3.delete();
`ifdef PIPE_STAGE_PERF_EN
      mbub2 = 0;
      mbub3 = 0;
`endif
    end else begin
      m_push2 = in_valid  && (q2.size() != 2);
      m_pop2  = out_ready && (q2.size() != 0);
      m_push3 = in_valid  && (q3.size() != 3);
      m_pop3  = out_ready && (q3.size() != 0);
`ifdef PIPE_STAGE_PERF_EN
      if (flush) mbub2 = 0;
      else if (out_ready && q2.size() == 0 && mbub2 != 32'hFFFF_FFFF) mbub2++;
      if (flush) mbub3 = 0;
      else if (out_ready && q3.size() == 0 && mbub3 != 32'hFFFF_FFFF) mbub3++;
`endif
      if (flush) begin
        q2.delete();
        q3.delete();
      end else begin
        if (m_pop2)  void'(q2.pop_front());
        if (m_push2) q2.push_back({in_pcincr, in_data});
        if (m_pop3)  void'(q3.pop_front());
        if (m_push3) q3.push_back({in_pcincr, in_data});
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_valid2",  32'(out_valid2),  32'd0);
      check("rst_pcincr2", 32'(out_pcincr2), 32'd0);
      check("rst_count2",  32'(count2),      32'd0);
      check("rst_valid3",  32'(out_valid3),  32'd0);
      check("rst_pcincr3", 32'(out_pcincr3), 32'd0);
      check("rst_count3",  32'(count3),      32'd0);
    end else begin
      check("count2",     32'(count2),    32'(q2.size()));
      check("in_ready2",  32'(in_ready2), 32'(q2.size() != 2));
      check("out_valid2", 32'(out_valid2), 32'(q2.size() != 0));
      if (q2.size() != 0) begin
        check("out_data2",  32'(out_data2), 32'(q2[0][W-1:0]));
        check("pcincr2", 32'(out_pcincr2), 32'(out_ready && !flush && q2[0][W]));
      end else begin
        check("pcincr2_empty", 32'(out_pcincr2), 32'd0);
      end
      check("count3",     32'(count3),    32'(q3.size()));
      check("in_ready3",  32'(in_ready3), 32'(q3.size() != 3));
      check("out_valid3", 32'(out_valid3), 32'(q3.size() != 0));
      if (q3.size() != 0) begin
        check("out_data3",  32'(out_data3), 32'(q3[0][W-1:0]));
        check("pcincr3", 32'(out_pcincr3), 32'(out_ready && !flush && q3[0][W]));
      end else begin
        check("pcincr3_empty", 32'(out_pcincr3), 32'd0);
      end
`ifdef PIPE_STAGE_PERF_EN
      check("bubble2", bubble2, mbub2);
      check("bubble3", bubble3, mbub3);
`endif
    end
    if (out_pcincr3) pulses3++;
  end

  task automatic set_in(input logic v, input logic [W-1:0] d, input logic pc,
                        input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_pcincr = pc;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] exp_data;
    logic         exp_pc [3];

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("lit_reset_count2", 32'(count2), 32'd0);
    check("lit_reset_ready2", 32'(in_ready2), 32'd1);
    check("lit_reset_valid2", 32'(out_valid2), 32'd0);

    // Fill DEPTH=2 with downstream stalled.
    set_in(1, 16'hA, 0, 0, 0); tick();
    set_in(1, 16'hB, 0, 0, 0); tick();
    set_in(0, '0, 0, 0, 0);
    check("lit_fill_count2", 32'(count2), 32'd2);
    check("lit_fill_ready2", 32'(in_ready2), 32'd0);
    check("lit_fill_data2",  32'(out_data2), 32'hA);
    check("lit_fill_model",  32'(q2.size()), 32'd2);

    // Push and pop together while FULL: pop happens, push refused.
    set_in(1, 16'hC, 0, 1, 0); #1;
    check("lit_full_ready2", 32'(in_ready2), 32'd0);
    tick();
    set_in(0, '0, 0, 0, 0);
    check("lit_full_count2", 32'(count2), 32'd1);
    check("lit_full_ready2b", 32'(in_ready2), 32'd1);
    check("lit_full_data2",  32'(out_data2), 32'hB);
    check("lit_full_count3", 32'(count3), 32'd2);
    set_in(0, '0, 0, 1, 0); tick(); tick();
    set_in(0, '0, 0, 0, 0);
    check("lit_drain_count3", 32'(count3), 32'd0);

    // pcincr pulses on 1st and 3rd pops.
    set_in(1, 16'h11, 1, 0, 0); tick();
    set_in(1, 16'h12, 0, 0, 0); tick();
    set_in(1, 16'h13, 1, 0, 0); tick();
    exp_pc[0] = 1'b1; exp_pc[1] = 1'b0; exp_pc[2] = 1'b1;
    pulses3 = 0;
    set_in(0, '0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_data = W'(16'h11 + k);
      check("lit_pc_data3",  32'(out_data3),   32'(exp_data));
      check("lit_pc_pulse3", 32'(out_pcincr3), 32'(exp_pc[k]));
      tick();
    end
    check("lit_pc_total3", 32'(pulses3), 32'd2);
    check("lit_pc_count3", 32'(count3), 32'd0);

    // Flush with a simultaneous push and pop.
    set_in(1, 16'h21, 1, 0, 0); tick();
    set_in(1, 16'h22, 1, 0, 0); tick();
    set_in(1, 16'hD, 0, 1, 1); #1;
    check("lit_flush_pc2", 32'(out_pcincr2), 32'd0);
    check("lit_flush_pc3", 32'(out_pcincr3), 32'd0);
    tick();
    set_in(0, '0, 0, 1, 0);
    check("lit_flush_count2", 32'(count2), 32'd0);
    check("lit_flush_valid2", 32'(out_valid2), 32'd0);
    check("lit_flush_count3", 32'(count3), 32'd0);
    tick(); tick();
    check("lit_flush_valid2b", 32'(out_valid2), 32'd0);
    // Flush while empty, then confirm the stage still works from slot 0.
    set_in(0, '0, 0, 0, 1); tick();
    set_in(1, 16'h33, 0, 0, 0); tick();
    set_in(0, '0, 0, 0, 0);
    check("lit_eflush_count2", 32'(count2), 32'd1);
    check("lit_eflush_data2",  32'(out_data2), 32'h33);
    set_in(0, '0, 0, 1, 0); tick();

    // Streaming through DEPTH=3 with wrap.
    for (int i = 1; i <= 7; i++) begin
      set_in(1, W'(i), 0, 1, 0); #1;
      if (i > 1) check("lit_stream_data3", 32'(out_data3), 32'(i - 1));
      tick();
      check("lit_stream_count3", 32'(count3), 32'd1);
    end
    set_in(0, '0, 0, 1, 0); #1;
    check("lit_stream_last3", 32'(out_data3), 32'h7);
    tick();
    check("lit_stream_end3", 32'(count3), 32'd0);

    // Asynchronous reset mid-cycle with two entries stored.
    set_in(1, 16'h41, 1, 0, 0); tick();
    set_in(1, 16'h42, 1, 0, 0); tick();
    set_in(0, '0, 0, 1, 0);
    #2 rst = 1'b0;
    #1;
    check("lit_arst_valid2",  32'(out_valid2),  32'd0);
    check("lit_arst_pc2",     32'(out_pcincr2), 32'd0);
    check("lit_arst_count2",  32'(count2),      32'd0);
    check("lit_arst_valid3",  32'(out_valid3),  32'd0);
    tick(); tick();
    rst = 1'b1;
    check("lit_arst_ready2", 32'(in_ready2), 32'd1);
    repeat (5) tick();
`ifdef PIPE_STAGE_PERF_EN
    check("lit_bubble2", bubble2, 32'd5);
    check("lit_bubble3", bubble3, 32'd5);
`endif

    // Randomized traffic, including rare flushes and async resets.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 9) < 7, W'($urandom), 1'($urandom),
             $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
- REQ-001 SHALL have parameter WIDTH, default 32: payload bits per entry (decoded-instruction bundle).
- REQ-002 SHALL have parameter DEPTH, default 2: number of entries, legal range 2..8.
- REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst, input, 1: reset, asynchronous assert, active-low.
- REQ-005 SHALL have port in_valid, input, 1: upstream entry offered.
- REQ-006 SHALL have port in_data, input, WIDTH: upstream payload.
- REQ-007 SHALL have port in_pcincr, input, 1: entry carries a PC-increment request.
- REQ-008 SHALL have port in_ready, output, 1: buffer can accept this cycle.
- REQ-009 SHALL have port flush, input, 1: synchronous discard of all entries (branch/exception).
- REQ-010 SHALL have port out_valid, output, 1: head entry present.
- REQ-011 SHALL have port out_data, output, WIDTH: head payload.
- REQ-012 SHALL have port out_ready, input, 1: downstream consumes the head this cycle.
- REQ-013 SHALL have port out_pcincr, output, 1: one-cycle PC-increment pulse to the register file.
- REQ-014 SHALL have port count, output, clog2(DEPTH+1): current occupancy.

Function
- REQ-015 Push SHALL occur when in_valid and in_ready are both high; pop SHALL occur when out_valid and out_ready are both high.
- REQ-016 in_ready SHALL equal (count != DEPTH) and SHALL be a function of registered state only, with no combinational path from out_ready.
- REQ-017 out_valid SHALL equal (count != 0); out_data SHALL be the oldest entry (FIFO order).
- REQ-018 A pushed entry SHALL appear at out_data no earlier than the cycle after the push; fall-through latency SHALL be 1 cycle.
- REQ-019 Occupancy states SHALL be EMPTY (count 0), PARTIAL (0<count<DEPTH) and FULL (count DEPTH).
- REQ-020 Transitions: push without pop SHALL increment count; pop without push SHALL decrement it; push with pop SHALL hold it.
- REQ-021 When FULL, a simultaneous pop SHALL free a slot only from the next cycle, since in_ready is low that cycle.
- REQ-022 Read and write pointers SHALL be log2-width and SHALL wrap from DEPTH-1 to 0; non-power-of-two DEPTH SHALL wrap explicitly.
- REQ-023 out_pcincr SHALL equal the pop condition ANDed with the head's stored pcincr bit, so exactly one pulse is produced per consumed entry.
- REQ-024 flush SHALL set count and both pointers to 0 at the next edge; a push in the same cycle SHALL be discarded; out_pcincr SHALL be forced to 0 during a flush cycle.
- REQ-025 flush while EMPTY SHALL be a no-op.

Reset
- REQ-026 rst low SHALL asynchronously clear count, the pointers and the stored pcincr bits.
- REQ-027 During reset: out_valid 0, out_pcincr 0, in_ready 1 after release, count 0; out_data SHALL be don't-care.
- REQ-028 Reset asserted mid-transfer SHALL discard all entries; no pcincr pulse SHALL be emitted.

Configuration
- REQ-029 With macro PIPE_STAGE_PERF_EN defined, the block SHALL add a 32-bit output bubble_cnt, reset to 0. It SHALL increment, saturating at 0xFFFFFFFF, on each cycle with out_ready=1 and out_valid=0, and it SHALL clear on flush.
- REQ-030 Without PIPE_STAGE_PERF_EN, the bubble_cnt port and counter SHALL be absent.

Structure
- REQ-031 The shared pipeline package SHALL hold the default WIDTH, the DEPTH limits and the occupancy-state encodings EMPTY, PARTIAL and FULL.
- REQ-032 Entry storage SHALL be one sub-module, pipe_stage_mem (DEPTH x (WIDTH+1) register array, one write port, one async read port); the control logic SHALL stay in the top module.

Verification
- REQ-033 Fill: DEPTH=2, out_ready=0, push 0xA, then 0xB -> count 2, in_ready 0, out_data 0xA.
- REQ-034 Full push-and-pop: from FULL, out_ready=1 and in_valid=1 with 0xC -> 0xA popped, 0xC not accepted, count 1, in_ready 1 next cycle.
- REQ-035 Streaming with wrap: DEPTH=3, push 0x1..0x7 with out_ready=1 every cycle -> outputs 0x1..0x7 in order, count never exceeds 1 after warm-up.
- REQ-036 pcincr: push entries with pcincr 1,0,1, then pop all -> exactly two out_pcincr pulses, on the 1st and 3rd pops.
- REQ-037 Flush with push: count 2, flush=1 and in_valid=1 with 0xD -> count 0, out_valid 0, and 0xD is never output.
- REQ-038 Reset and perf counter: drop rst while count is 2 -> out_valid 0 immediately; with PIPE_STAGE_PERF_EN defined, 5 idle cycles with out_ready=1 -> bubble_cnt 5.
